// File: rtl/pixel_config_seq_if.sv
// pixel_config_seq_if
// Groups the host command, host word FIFO and Pixle_Config shifter signals
// seen by pixel_config_seq.
//   master : the environment (host + FIFO + shifter). It drives the commands,
//            the FIFO head/flag and BUSY, and it observes the sequencer outputs.
//   slave  : the sequencer itself.
// Parameters:
//   DIV_WIDTH : width of the shifter clock divider
//   NW_WIDTH  : width of the word-count field
interface pixel_config_seq_if #(
  parameter int DIV_WIDTH = 6,
  parameter int NW_WIDTH  = 8
);

  // Host command / status
  logic                 CMD_START;
  logic                 CMD_ABORT;
  logic [NW_WIDTH-1:0]  CMD_NWORDS;
  logic [DIV_WIDTH-1:0] CMD_DIV;
  logic                 SEQ_ACTIVE;
  logic                 DONE;
  logic                 ERR_TIMEOUT;

  // Host word FIFO (first-word-fall-through)
  logic [31:0]          FIFO_DATA;
  logic                 FIFO_EMPTY;
  logic                 FIFO_RD_EN;

  // Pixle_Config shifter side
  logic [DIV_WIDTH-1:0] DIV;
  logic [31:0]          SRAM_DATA;
  logic                 SRAM_WE;
  logic                 pulse_start;
  logic                 BUSY;

  modport master (
    output CMD_START, CMD_ABORT, CMD_NWORDS, CMD_DIV,
    output FIFO_DATA, FIFO_EMPTY, BUSY,
    input  FIFO_RD_EN, DIV, SRAM_DATA, SRAM_WE, pulse_start,
    input  SEQ_ACTIVE, DONE, ERR_TIMEOUT
  );

  modport slave (
    input  CMD_START, CMD_ABORT, CMD_NWORDS, CMD_DIV,
    input  FIFO_DATA, FIFO_EMPTY, BUSY,
    output FIFO_RD_EN, DIV, SRAM_DATA, SRAM_WE, pulse_start,
    output SEQ_ACTIVE, DONE, ERR_TIMEOUT
  );

endinterface

// File: rtl/pixel_config_seq.sv
// pixel_config_seq
// Sequencer that feeds one Pixle_Config pixel-configuration shifter from a
// host word FIFO. On CMD_START it latches the divider, streams CMD_NWORDS
// 32-bit words from the FIFO into the shifter SRAM port, fires pulse_start
// and follows the shifter BUSY handshake until completion.
//
// Ports:
//   SYS_CLK  in  system clock, rising edge
//   RESET_N  in  asynchronous active-low reset
//   bus      pixel_config_seq_if.slave
//            CMD_START/CMD_ABORT/CMD_NWORDS/CMD_DIV  host command
//            FIFO_DATA/FIFO_EMPTY/FIFO_RD_EN         FWFT word FIFO
//            DIV/SRAM_DATA/SRAM_WE/pulse_start/BUSY  shifter side
//            SEQ_ACTIVE/DONE/ERR_TIMEOUT             status
//
// Build option:
//   PIXEL_CFG_SEQ_TIMEOUT_EN  when defined, WAIT_ACK is bounded by ACK_TIMEOUT
//   cycles and WAIT_DONE by 2^DONE_TO_WIDTH-1 cycles; expiry goes through
//   ERROR and sets the sticky ERR_TIMEOUT. When undefined, both waits are
//   unbounded (CMD_ABORT is the only escape) and ERR_TIMEOUT is tied low.
module pixel_config_seq #(
  parameter int DIV_WIDTH     = 6,
  parameter int NW_WIDTH      = 8,
  parameter int ACK_TIMEOUT   = 64,
  parameter int DONE_TO_WIDTH = 20
) (
  input  logic             SYS_CLK,
  input  logic             RESET_N,
  pixel_config_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    START,
    WAIT_ACK,
    WAIT_DONE,
    ERROR
  } state_t;

  state_t               state;
  state_t               next_state;

  logic [NW_WIDTH-1:0]  nwords_q;
  logic [NW_WIDTH-1:0]  wcnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 start_q;
  logic                 done_q;
  logic                 active_q;

  logic                 accept;
  logic                 pop_p0;
  logic                 last_word;
  logic [31:0]          sram_data_p1;
  logic                 vld_p1;

  logic                 ack_expired;
  logic                 done_expired;

  assign accept    = (state == IDLE) && bus.CMD_START && !bus.CMD_ABORT;
  assign last_word = (wcnt_q == (nwords_q - NW_WIDTH'(1)));

`ifdef PIXEL_CFG_SEQ_TIMEOUT_EN
  // One shared counter serves both waits; it is wide enough for either limit.
  localparam int TO_ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int TO_W     = (DONE_TO_WIDTH > TO_ACK_W) ? DONE_TO_WIDTH : TO_ACK_W;
  // The counter reads 0 in the first wait cycle, so LAST is the final
  // allowed cycle: ACK_TIMEOUT cycles in WAIT_ACK, 2^DONE_TO_WIDTH-1 in WAIT_DONE.
  localparam logic [TO_W-1:0] ACK_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] DONE_LAST = TO_W'({DONE_TO_WIDTH{1'b1}}) - TO_W'(1);

  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (&v) ? v : v + TO_W'(1);
  endfunction

  assign ack_expired  = (to_cnt_q == ACK_LAST);
  assign done_expired = (to_cnt_q == DONE_LAST);

  // Runs only while staying in a wait state; any other cycle (START,
  // WAIT_ACK->WAIT_DONE hand-over, abort) clears it.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      to_cnt_q <= '0;
    end else if (((state == WAIT_ACK)  && (next_state == WAIT_ACK)) ||
                 ((state == WAIT_DONE) && (next_state == WAIT_DONE))) begin
      to_cnt_q <= sat_inc(to_cnt_q);
    end else begin
      to_cnt_q <= '0;
    end
  end

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if ((state == ERROR) && !bus.CMD_ABORT) begin
      err_q <= 1'b1;
    end
  end

  assign bus.ERR_TIMEOUT = err_q;
`else
  logic unused_cfg;

  assign ack_expired     = 1'b0;
  assign done_expired    = 1'b0;
  assign bus.ERR_TIMEOUT = 1'b0;
  assign unused_cfg      = (ACK_TIMEOUT > 0) ^ (DONE_TO_WIDTH > 0);
`endif

  always_comb begin
    next_state = state;
    if (bus.CMD_ABORT) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Zero words re-shifts whatever the shifter SRAM already holds.
          if (bus.CMD_START) begin
            next_state = (bus.CMD_NWORDS == '0) ? START : LOAD;
          end
        end
        LOAD: begin
          if (pop_p0 && last_word) begin
            next_state = FLUSH;
          end
        end
        FLUSH:    next_state = START;
        START:    next_state = WAIT_ACK;
        WAIT_ACK: begin
          if (bus.BUSY) begin
            next_state = WAIT_DONE;
          end else if (ack_expired) begin
            next_state = ERROR;
          end
        end
        WAIT_DONE: begin
          if (!bus.BUSY) begin
            next_state = IDLE;
          end else if (done_expired) begin
            next_state = ERROR;
          end
        end
        ERROR:    next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  // Stage p0: pop decision, combinational from state and the FIFO flag.
  assign pop_p0 = (state == LOAD) && !bus.FIFO_EMPTY && !bus.CMD_ABORT;

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      nwords_q <= '0;
      wcnt_q   <= '0;
      div_q    <= '0;
      vld_p1   <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        nwords_q <= bus.CMD_NWORDS;
        div_q    <= bus.CMD_DIV;
        wcnt_q   <= '0;
      end else if (pop_p0) begin
        wcnt_q   <= wcnt_q + NW_WIDTH'(1);
      end
      vld_p1   <= pop_p0;
      start_q  <= (next_state == START);
      done_q   <= (state == WAIT_DONE) && !bus.BUSY && !bus.CMD_ABORT;
      active_q <= (next_state != IDLE);
    end
  end

  // Stage p1: popped word registered and presented to the shifter SRAM port.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sram_data_p1 <= '0;
    end else if (pop_p0) begin
      sram_data_p1 <= bus.FIFO_DATA;
    end
  end

  // Abort masks the registered strobes in the very cycle it is raised; the
  // held word is dropped because vld_p1 reloads from the (masked) pop.
  assign bus.FIFO_RD_EN  = pop_p0;
  assign bus.SRAM_WE     = vld_p1 && !bus.CMD_ABORT;
  assign bus.SRAM_DATA   = sram_data_p1;
  assign bus.pulse_start = start_q && !bus.CMD_ABORT;
  assign bus.DIV         = div_q;
  assign bus.SEQ_ACTIVE  = active_q;
  assign bus.DONE        = done_q;

endmodule

// File: doc/pixel_config_seq.md
# pixel_config_seq

Sequencer that drives one `Pixle_Config` pixel-configuration shifter from a host word FIFO. On a host command it:
- latches the clock divider,
- streams N 32-bit configuration words from the FIFO into the shifter's SRAM port,
- fires `pulse_start`,
- tracks the shifter's `BUSY` handshake to completion.

It sits between the host control-register/FIFO interface and `Pixle_Config`, and reports done and timeout status.

## Interface
- `DIV_WIDTH`, 6: width of the divider passed to the shifter.
- `NW_WIDTH`, 8: width of the word-count field; maximum load is 2^NW_WIDTH-1 words.
- `ACK_TIMEOUT`, 64: maximum cycles allowed from `pulse_start` until `BUSY` is seen high.
- `DONE_TO_WIDTH`, 20: width of the done-timeout counter; the limit is 2^DONE_TO_WIDTH-1 cycles.
- `SYS_CLK`  in  1  system clock; everything is sampled on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `CMD_START`  in  1  one-cycle request to start a sequence; honoured only in IDLE.
- `CMD_ABORT`  in  1  forces IDLE from any state; takes priority over every other input.
- `CMD_NWORDS`  in  NW_WIDTH  number of words to load; latched on `CMD_START`.
- `CMD_DIV`  in  DIV_WIDTH  divider value; latched on `CMD_START`.
- `FIFO_DATA`  in  32  first-word-fall-through FIFO head word.
- `FIFO_EMPTY`  in  1  FIFO empty flag.
- `FIFO_RD_EN`  out  1  FIFO pop.
- `DIV`  out  DIV_WIDTH  latched divider driven to the shifter.
- `SRAM_DATA`  out  32  configuration word to the shifter.
- `SRAM_WE`  out  1  write strobe to the shifter.
- `pulse_start`  out  1  one-cycle start pulse to the shifter.
- `BUSY`  in  1  shifter busy flag.
- `SEQ_ACTIVE`  out  1  high whenever the state is not IDLE.
- `DONE`  out  1  one-cycle pulse on successful completion.
- `ERR_TIMEOUT`  out  1  sticky timeout flag.

## Operation
States: IDLE, LOAD, FLUSH, START, WAIT_ACK, WAIT_DONE, ERROR.

- **IDLE**
  - `CMD_START=1`: latch `CMD_NWORDS` and `CMD_DIV`, clear `ERR_TIMEOUT` and the word counter.
  - Next state is LOAD, or START directly if `CMD_NWORDS=0`. With zero words, the existing SRAM contents are re-shifted.
- **LOAD**
  - `FIFO_RD_EN = !FIFO_EMPTY` (combinational from state). Each pop increments the word counter.
  - Each popped word is registered; `SRAM_WE=1` and `SRAM_DATA` equal that word on the next cycle.
  - `FIFO_EMPTY` stalls the load with no timeout, and `SRAM_WE` is 0 during stall cycles.
  - The pop that brings the count to NWORDS moves the state to FLUSH.
- **FLUSH**: last `SRAM_WE` pulse; no pop. Next state is START.
- **START**: `pulse_start=1` for exactly one cycle; the timeout counter clears. Next state is WAIT_ACK.
- **WAIT_ACK**
  - `BUSY=1` (level, so `BUSY` already high counts): next state is WAIT_DONE and the counter clears.
  - Counter reaching `ACK_TIMEOUT`: next state is ERROR.
- **WAIT_DONE**
  - `BUSY=0`: pulse `DONE` and go to IDLE.
  - Counter reaching 2^DONE_TO_WIDTH-1: next state is ERROR.
- **ERROR**: set `ERR_TIMEOUT`; next state is IDLE. There is no `DONE` pulse.
- **CMD_ABORT** from any state:
  - Next state is IDLE; `SRAM_WE`, `pulse_start` and `FIFO_RD_EN` go to 0 that cycle.
  - The registered word is discarded; the FIFO is not drained.
  - `ERR_TIMEOUT` is unchanged.
- `CMD_START` outside IDLE is ignored. Simultaneous `CMD_START` and `CMD_ABORT` in IDLE: abort wins and the state stays IDLE.
- `DIV` changes only on an accepted `CMD_START`, so it is held stable throughout a sequence.

## Timing
- Reset values: state IDLE; `DIV`=0, `SRAM_DATA`=0, `SRAM_WE`=0, `pulse_start`=0, `FIFO_RD_EN`=0, `SEQ_ACTIVE`=0, `DONE`=0, `ERR_TIMEOUT`=0.
- Reset asserted mid-sequence returns to these values immediately; no pulse is emitted.
- All outputs except `FIFO_RD_EN` are registered.
- `CMD_START` at cycle 0, FIFO never empty, N≥1:
  - pops in cycles 1..N;
  - `SRAM_WE` in cycles 2..N+1, with FLUSH at cycle N+1;
  - `pulse_start` in cycle N+2.
- `CMD_START` at cycle 0 with N=0: `pulse_start` in cycle 1.
- Timeout counters run only in WAIT_ACK and WAIT_DONE and saturate; they do not wrap.
- The word counter is NW_WIDTH bits and never wraps, because exit occurs at NWORDS.

## Configuration
- `PIXEL_CFG_SEQ_TIMEOUT_EN` defined:
  - Timeout counters and the ERROR state are built as described above.
- Not defined:
  - Counters and ERROR are removed.
  - WAIT_ACK and WAIT_DONE wait indefinitely for `BUSY`.
  - `ERR_TIMEOUT` is tied to 0.
  - `CMD_ABORT` is the only escape from these waits.

## Test plan
- **Nominal load:** `CMD_DIV`=2, N=21, FIFO preloaded with 0xC002E001 incrementing by 0x00010001 per word, `BUSY` model high 10 cycles after `pulse_start` and for 250 cycles.
  - 21 `SRAM_WE` pulses carrying the exact words in order.
  - `pulse_start` exactly 1 cycle after the last write.
  - `DIV`=2 throughout.
  - `DONE` once; `ERR_TIMEOUT`=0.
- **FIFO stall:** N=4, FIFO empty for 5 cycles after word 2.
  - `SRAM_WE` gap of 5 cycles.
  - Still 4 writes, 1 `pulse_start`, `DONE`.
- **Zero words:** N=0.
  - No `FIFO_RD_EN` and no `SRAM_WE`.
  - `pulse_start` in the cycle after `CMD_START`; `DONE` after `BUSY` falls.
- **Ack timeout (macro on):** `ACK_TIMEOUT`=64, `BUSY` never rises.
  - `ERR_TIMEOUT`=1 after 64 WAIT_ACK cycles; no `DONE`.
  - The next `CMD_START` clears the flag.
- **Abort and reset:** `CMD_ABORT` at write 3 of 10.
  - Outputs idle in the same cycle; `SEQ_ACTIVE`=0 the next cycle.
  - A later `CMD_START` works normally.
  - Repeat with `RESET_N` low mid-WAIT_DONE: all outputs return to reset values immediately.
